// File: rtl/node_integrator_saturating.sv
// Saturating node integrator: sums N signed contributor currents each enabled step into a clamped node voltage.
// Optional feature macro: NODE_HYSTERESIS_EN selects a registered hysteretic digital level instead of the sign bit.
module node_integrator_saturating #(
    parameter int                  N             = 4,
    parameter int                  W             = 8,
    parameter logic signed [W-1:0] VHI           = W'(64),
    parameter logic signed [W-1:0] VLO           = W'(-64),
    parameter logic signed [W-1:0] VINIT         = W'(-64),
    parameter int                  SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N*W-1:0]   i_bus,
    output logic [W-1:0]     v,
    output logic             d,
    output logic             settled
);

    localparam int SW = W + $clog2(N) + 1;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);

    logic signed [SW-1:0] cur_ext [N];
    logic signed [SW-1:0] sum;
    logic signed [SW:0]   raw;
    logic signed [SW:0]   hi_ext;
    logic signed [SW:0]   lo_ext;
    logic signed [W-1:0]  v_next;

    logic signed [W-1:0]  v_q, v_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 settled_q, settled_d;

    // Each contributor is sign-extended so the sum can never overflow.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cur
            assign cur_ext[gi] = {{(SW-W){i_bus[gi*W+W-1]}}, i_bus[gi*W +: W]};
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++) begin
            sum = sum + cur_ext[k];
        end
    end

    assign raw    = {{(SW+1-W){v_q[W-1]}}, v_q} + {sum[SW-1], sum};
    assign hi_ext = {{(SW+1-W){VHI[W-1]}}, VHI};
    assign lo_ext = {{(SW+1-W){VLO[W-1]}}, VLO};

    always_comb begin
        v_next = raw[W-1:0];
        if (raw > hi_ext) begin
            v_next = VHI;
        end else if (raw < lo_ext) begin
            v_next = VLO;
        end
    end

    // A step pinned against a rail leaves v unchanged and so advances the settle count.
    always_comb begin
        v_d       = v_q;
        cnt_d     = cnt_q;
        settled_d = settled_q;
        if (en) begin
            v_d = v_next;
            if (v_next == v_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            end else begin
                cnt_d = '0;
            end
            settled_d = (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q       <= VINIT;
            cnt_q     <= '0;
            settled_q <= 1'b0;
        end else begin
            v_q       <= v_d;
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
        end
    end

    assign v       = v_q;
    assign settled = settled_q;

`ifdef NODE_HYSTERESIS_EN
    typedef enum logic {D_LOW = 1'b0, D_HIGH = 1'b1} d_state_t;

    localparam logic signed [W-1:0] TH_HI = VHI >>> 1;
    localparam logic signed [W-1:0] TH_LO = VLO >>> 1;

    d_state_t d_state_q, d_state_d;

    always_comb begin
        d_state_d = d_state_q;
        if (en) begin
            case (d_state_q)
                D_LOW:   if (v_next >= TH_HI) d_state_d = D_HIGH;
                D_HIGH:  if (v_next <= TH_LO) d_state_d = D_LOW;
                default: d_state_d = D_LOW;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_state_q <= D_LOW;
        end else begin
            d_state_q <= d_state_d;
        end
    end

    assign d = (d_state_q == D_HIGH);
`else
    assign d = ~v_q[W-1];
`endif

endmodule

// File: tb/tb_node_integrator_saturating.sv
// Directed bench for node_integrator_saturating with W=8, N=2, rails +/-64, SETTLE_CYCLES=4.
module tb_node_integrator_saturating;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] i_bus;
    logic [7:0]  v;
    logic        d;
    logic        settled;

    int errors = 0;
    int checks = 0;

    node_integrator_saturating #(
        .N(2), .W(8), .VHI(8'sd64), .VLO(-8'sd64), .VINIT(-8'sd64), .SETTLE_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .i_bus(i_bus),
        .v(v), .d(d), .settled(settled)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step(input logic rst, input logic e, input int a, input int b);
        reset       = rst;
        en          = e;
        i_bus[7:0]  = 8'(a);
        i_bus[15:8] = 8'(b);
        @(posedge clk);
        #1;
    endtask

    function automatic int sv(input logic [7:0] x);
        return int'($signed(x));
    endfunction

    int  ve;
    int  dexp;

    initial begin
        reset = 1'b1; en = 1'b0; i_bus = '0;
        @(negedge clk);

        // 1. reset overrides en
        step(1, 1, 5, 5);
        check("reset_v", sv(v), -64);
        check("reset_d", int'(d), 0);
        check("reset_settled", int'(settled), 0);

        // 2. ramp by +2
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 2, 0);
            check($sformatf("ramp_v[%0d]", k), sv(v), -64 + 2*k);
            check($sformatf("ramp_settled[%0d]", k), int'(settled), 0);
        end

        // 3. saturation and settle
        step(1, 0, 0, 0);
        begin
            int exp_v [7] = '{-4, 56, 64, 64, 64, 64, 64};
            for (int k = 0; k < 7; k++) begin
                step(0, 1, 30, 30);
                check($sformatf("sat_v[%0d]", k+1), sv(v), exp_v[k]);
                check($sformatf("sat_settled[%0d]", k+1), int'(settled), (k == 6) ? 1 : 0);
            end
        end

        // 4. zero net current with en gaps
        step(1, 0, 0, 0);
        step(0, 1, 3, -3);
        step(0, 1, 3, -3);
        check("zero_settled_2", int'(settled), 0);
        step(0, 0, 3, -3);
        step(0, 0, 50, 50);
        check("gap_v_hold", sv(v), -64);
        check("gap_settled", int'(settled), 0);
        step(0, 1, 3, -3);
        check("zero_settled_3", int'(settled), 0);
        step(0, 1, 3, -3);
        check("zero_settled_4", int'(settled), 1);
        step(0, 1, 1, 0);
        check("bump_v", sv(v), -63);
        check("bump_settled", int'(settled), 0);

        // 5. digital level: up by +8 to 32, then down by -8 to -32
        step(1, 0, 0, 0);
        ve   = -64;
        dexp = 0;
        for (int k = 0; k < 20; k++) begin
            int inc;
            inc = (k < 12) ? 8 : -8;
            ve  = ve + inc;
            step(0, 1, inc, 0);
`ifdef NODE_HYSTERESIS_EN
            if (ve == 32)  dexp = 1;
            if (ve == -32) dexp = 0;
`else
            dexp = (ve >= 0) ? 1 : 0;
`endif
            check($sformatf("hyst_v[%0d]", k+1), sv(v), ve);
            check($sformatf("hyst_d[%0d]", k+1), int'(d), dexp);
        end

        // 6. reset mid-operation
        step(1, 0, 0, 0);
        step(0, 1, 26, 26);
        step(0, 1, 26, 26);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0);
        check("pre_rst_v", sv(v), 40);
        check("pre_rst_settled", int'(settled), 1);
        check("pre_rst_d", int'(d), 1);
        step(1, 1, 5, 5);
        check("mid_rst_v", sv(v), -64);
        check("mid_rst_settled", int'(settled), 0);
        check("mid_rst_d", int'(d), 0);
        step(0, 1, 2, 0);
        check("resume_v", sv(v), -62);
        check("resume_settled", int'(settled), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
